// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage : RV32I writeback stage.
//
// Accepts completed results from the ALU path and the load/store unit through
// valid/ready handshakes. Loads are sign/zero-extended according to funct3 and
// the byte offset. Both sources share the single register-file write port,
// which is driven from one output register stage (one cycle of latency).
//
// Default arbitration gives the LSU fixed priority. Defining the macro
// WB_ANTI_STARVE_EN adds a starvation counter. After STARVE_LIMIT consecutive
// cycles in which the ALU is denied, the ALU is given one guaranteed win.
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_rdata,
    input  logic [2:0]  lsu_funct3,
    input  logic [1:0]  lsu_offset,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        we,
    output logic        f3_err
);

    // Load funct3 encodings. Every other value is treated as illegal.
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    // The counter is 4 bits wide, so the limit must fit in it and be non-zero.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("wb_stage: STARVE_LIMIT must be in 1..15");
    end

    logic        w_alu_acc;
    logic        w_lsu_acc;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic        w_f3_illegal;

    // ------------------------------------------------------------------
    // Arbitration. The ready signals depend only on the valid inputs and on
    // local state, never on any data input.
    // ------------------------------------------------------------------
`ifdef WB_ANTI_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;
    logic       w_alu_prio;

    assign w_alu_prio = (r_starve_cnt == LIMIT);
    assign lsu_ready  = !w_alu_prio;
    assign alu_ready  = w_alu_prio || !lsu_valid;

    // Count consecutive cycles the ALU waits. The count saturates at LIMIT
    // and clears once the ALU wins or stops requesting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (!alu_valid || w_alu_acc) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`else
    assign lsu_ready = 1'b1;
    assign alu_ready = !lsu_valid;
`endif

    assign w_lsu_acc = lsu_valid && lsu_ready;
    // The two ready signals are mutually exclusive whenever both sources are valid.
    // The LSU gate is therefore redundant, but it states the one-winner rule explicitly.
    assign w_alu_acc = alu_valid && alu_ready && !w_lsu_acc;

    // Select the byte and halfword lanes addressed by the offset (little-endian).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_byte = lsu_rdata[7:0];
        case (lsu_offset)
            2'd0:    w_byte = lsu_rdata[7:0];
            2'd1:    w_byte = lsu_rdata[15:8];
            2'd2:    w_byte = lsu_rdata[23:16];
            default: w_byte = lsu_rdata[31:24];
        endcase
        // offset[0] is ignored for halfwords; alignment is guaranteed upstream.
        w_half = lsu_offset[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];
    end

    // Extend the selected lane according to funct3. Illegal encodings pass the word through.
    always_comb begin
        w_load_data  = lsu_rdata;
        w_f3_illegal = 1'b0;
        case (load_f3_e'(lsu_funct3))
            F3_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            F3_LW:   w_load_data = lsu_rdata;
            F3_LBU:  w_load_data = {24'd0, w_byte};
            F3_LHU:  w_load_data = {16'd0, w_half};
            default: w_f3_illegal = 1'b1;
        endcase
    end

    // Register the winning result into the register-file write port.
    // Writes to x0 are consumed silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            rd_addr <= 5'd0;
            rd_data <= 32'd0;
            we      <= 1'b0;
            f3_err  <= 1'b0;
        end else begin
            f3_err <= w_lsu_acc && w_f3_illegal;
            if (w_lsu_acc) begin
                rd_addr <= lsu_rd;
                rd_data <= w_load_data;
                we      <= (lsu_rd != 5'd0);
            end else if (w_alu_acc) begin
                rd_addr <= alu_rd;
                rd_data <= alu_data;
                we      <= (alu_rd != 5'd0);
            end else begin
                we      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage : self-checking bench for wb_stage.
//
// A behavioural model holds the expected write port and ready values.
// A negedge compare process checks the DUT against that model on every cycle.
// Directed sequences pin the model to hand-computed literal values.
// A randomized traffic phase with a mid-cycle reset follows.
// The model honours WB_ANTI_STARVE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_wb_stage;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_rdata;
    logic [2:0]  lsu_funct3;
    logic [1:0]  lsu_offset;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        we;
    logic        f3_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;
    int wr_cnt   = 0;

    always #5 clk = ~clk;

    wb_stage #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_rdata  (lsu_rdata),
        .lsu_funct3 (lsu_funct3),
        .lsu_offset (lsu_offset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .we         (we),
        .f3_err     (f3_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Format a raw load word with plain shifts and arithmetic.
    function automatic logic [31:0] model_load(input logic [31:0] w, input int f3, input int off);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (off >= 2) ? (w >> 16) : (w & 32'hFFFF);
        case (f3)
            0:       return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            1:       return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            4:       return b;
            5:       return h;
            default: return w;
        endcase
    endfunction

    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_we;
    logic        m_f3;
    logic        m_alu_acc_q;
    int          m_wait;
    logic        m_alu_ready;
    logic        m_lsu_ready;

    // Expected ready values: the LSU wins unless the ALU has waited LIMIT cycles
    // (only when the anti-starvation option is built in).
    always_comb begin
        m_lsu_ready = 1'b1;
        m_alu_ready = !lsu_valid;
`ifdef WB_ANTI_STARVE_EN
        if (m_wait == LIMIT) begin
            m_lsu_ready = 1'b0;
            m_alu_ready = 1'b1;
        end
`endif
    end

    always @(posedge clk or posedge rst) begin : model
        logic la, aa;
        if (rst) begin
            m_addr      <= '0;
            m_data      <= '0;
            m_we        <= 1'b0;
            m_f3        <= 1'b0;
            m_alu_acc_q <= 1'b0;
            m_wait      <= 0;
        end else begin
            la = lsu_valid && m_lsu_ready;
            aa = alu_valid && m_alu_ready && !la;
            m_alu_acc_q <= aa;
            m_f3        <= la && !(lsu_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            if (la) begin
                m_addr <= lsu_rd;
                m_data <= model_load(lsu_rdata, int'(lsu_funct3), int'(lsu_offset));
                m_we   <= (lsu_rd != 0);
            end else if (aa) begin
                m_addr <= alu_rd;
                m_data <= alu_data;
                m_we   <= (alu_rd != 0);
            end else begin
                m_we   <= 1'b0;
            end
            if (!alu_valid || aa) m_wait <= 0;
            else if (m_wait < LIMIT) m_wait <= m_wait + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("alu_ready", alu_ready, m_alu_ready);
            check("lsu_ready", lsu_ready, m_lsu_ready);
            check("we",        we,        m_we);
            check("f3_err",    f3_err,    m_f3);
            check("rd_addr",   rd_addr,   m_addr);
            check("rd_data",   rd_data,   m_data);
        end
        if (we) wr_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"},   we,      0);
        check({tag, "_addr"}, rd_addr, 0);
        check({tag, "_data"}, rd_data, 0);
        check({tag, "_f3"},   f3_err,  0);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] exp;
        logic        err;
    } load_vec_t;

    load_vec_t lvec [7] = '{
        '{3'b000, 2'd0, 32'hFFFF_FF82, 1'b0},
        '{3'b100, 2'd0, 32'h0000_0082, 1'b0},
        '{3'b000, 2'd1, 32'h0000_007F, 1'b0},
        '{3'b001, 2'd2, 32'hFFFF_80F1, 1'b0},
        '{3'b101, 2'd2, 32'h0000_80F1, 1'b0},
        '{3'b010, 2'd0, 32'h80F1_7F82, 1'b0},
        '{3'b011, 2'd0, 32'h80F1_7F82, 1'b1}
    };

    initial begin
        int alu_wins;
        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_rdata = 0; lsu_funct3 = 0; lsu_offset = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        chk_en = 1'b1;

        // ALU only
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF;
        #1 check("alu_only_ready", alu_ready, 1);
        step();
        alu_valid = 0;
        check("alu_only_we",   we,      1);
        check("alu_only_addr", rd_addr, 5);
        check("alu_only_data", rd_data, 32'hDEAD_BEEF);
        step();
        check("alu_only_we_drop", we, 0);

        // Load formatting
        for (int i = 0; i < 7; i++) begin
            lsu_valid = 1; lsu_rd = 5'(10 + i); lsu_rdata = 32'h80F1_7F82;
            lsu_funct3 = lvec[i].f3; lsu_offset = lvec[i].off;
            step();
            lsu_valid = 0;
            check($sformatf("load%0d_data", i), rd_data, lvec[i].exp);
            check($sformatf("load%0d_we", i),   we,      1);
            check($sformatf("load%0d_f3", i),   f3_err,  lvec[i].err);
            step();
            check($sformatf("load%0d_f3_drop", i), f3_err, 0);
        end

        // Collision: LSU first, ALU held and written next
        wr_cnt = 0;
        alu_valid = 1; alu_rd = 3; alu_data = 32'h3333_3333;
        lsu_valid = 1; lsu_rd = 7; lsu_rdata = 32'h7777_7777; lsu_funct3 = 3'b010; lsu_offset = 0;
        #1 check("coll_alu_ready", alu_ready, 0);
        step();
        lsu_valid = 0;
        check("coll_first_addr", rd_addr, 7);
        check("coll_first_we",   we,      1);
        #1 check("coll_alu_ready2", alu_ready, 1);
        step();
        alu_valid = 0;
        check("coll_second_addr", rd_addr, 3);
        check("coll_second_data", rd_data, 32'h3333_3333);
        check("coll_second_we",   we,      1);
        step();
        check("coll_idle_we", we, 0);
        step();
        check("coll_write_count", wr_cnt, 2);

        // x0 writes are consumed without a write enable
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234_5678;
        #1 check("x0_alu_ready", alu_ready, 1);
        step();
        alu_valid = 0;
        check("x0_alu_we", we, 0);
        lsu_valid = 1; lsu_rd = 0; lsu_funct3 = 3'b010;
        #1 check("x0_lsu_ready", lsu_ready, 1);
        step();
        lsu_valid = 0;
        check("x0_lsu_we", we, 0);
        step();

        // Both sources held continuously
        alu_wins = 0;
        alu_valid = 1; alu_rd = 9;  alu_data = 32'h0000_0009;
        lsu_valid = 1; lsu_rd = 11; lsu_rdata = 32'h0000_000B; lsu_funct3 = 3'b010;
        for (int i = 0; i < 20; i++) begin
            step();
            if (we && rd_addr == 5'd9) alu_wins++;
        end
`ifdef WB_ANTI_STARVE_EN
        check("starve_alu_wins", alu_wins, 20 / (LIMIT + 1));
`else
        check("starve_alu_wins", alu_wins, 0);
`endif
        alu_valid = 0; lsu_valid = 0;
        step();

        // Randomized traffic; the ALU holds each transaction until accepted.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                @(negedge clk);
                #2 rst = 1'b1;
                #1 check_zero("mid_reset");
                @(posedge clk);
                #1 rst = 1'b0;
            end
            lsu_valid  = ($urandom_range(0, 1) == 1);
            lsu_rd     = 5'($urandom_range(0, 31));
            lsu_rdata  = $urandom;
            lsu_funct3 = 3'($urandom_range(0, 7));
            lsu_offset = 2'($urandom_range(0, 3));
            step();
            if (!alu_valid || m_alu_acc_q) begin
                alu_valid = ($urandom_range(0, 9) < 6);
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
        end
        alu_valid = 0; lsu_valid = 0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
